io_bus_fabric: RTL and testbench
================================

IO_BUS_FABRIC -- requirements
Module: io_bus_fabric

Interface
REQ-001 SHALL have parameter NDEV, default 4, meaning number of device slots (power of 2, 2..16); SEL_W = log2(NDEV).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning CPU IO address width; top SEL_W bits select the device.
REQ-003 SHALL have parameter TIMEOUT, default 31, meaning the maximum ACCESS cycles before bus error; SHALL be greater than 15.
REQ-004 clk_i  in  1  clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 cpu_cyc  in  1  CPU requests an IO cycle; held high until cpu_ack or cpu_err.
REQ-007 cpu_we  in  1  1 = write, 0 = read.
REQ-008 cpu_addr  in  ADDR_W  IO address.
REQ-009 cpu_wdata  in  8  write data.
REQ-010 cpu_rdata  out  8  read data, held until the next completion.
REQ-011 cpu_ack  out  1  one-cycle pulse, transaction completed.
REQ-012 cpu_err  out  1  one-cycle pulse, transaction failed.
REQ-013 dev_en  in  NDEV  per-slot enable mask.
REQ-014 ws_cfg  in  4*NDEV  per-slot minimum wait states; slot k uses bits [4k+3:4k].
REQ-015 dev_cyc  out  NDEV  one-hot cycle strobe to the selected slot.
REQ-016 dev_we  out  NDEV  one-hot write strobe, same timing as dev_cyc.
REQ-017 dev_addr  out  ADDR_W-SEL_W  latched low address bits, shared by all slots.
REQ-018 dev_wdata  out  8  latched write data, shared.
REQ-019 dev_rdata  in  8*NDEV  slot k read data on bits [8k+7:8k].
REQ-020 dev_ack  in  NDEV  per-slot ready.
REQ-021 err_count  out  8  saturating bus-error counter.
REQ-022 last_err_addr  out  ADDR_W  address of the most recent errored transaction.

Function
REQ-023 SHALL implement FSM states IDLE, ACCESS, DONE, ERR.
REQ-024 IDLE with cpu_cyc=1: SHALL latch cpu_addr, cpu_we and cpu_wdata, and compute sel = addr[ADDR_W-1 -: SEL_W].
REQ-025 IDLE transition: go to ACCESS if dev_en[sel]=1, else go to ERR.
REQ-026 On entering ACCESS: SHALL load the wait counter with ws_cfg[sel] and clear the timeout counter.
REQ-027 In ACCESS: dev_cyc[sel]=1 and dev_we[sel]=latched we; all other slot bits 0.
REQ-028 In ACCESS: the wait counter decrements each cycle while nonzero, and the timeout counter increments each cycle.
REQ-029 Qualified ack = wait counter = 0 and dev_ack[sel] = 1.
REQ-030 On a qualified ack: SHALL go to DONE, capturing dev_rdata[sel] into cpu_rdata on reads only; writes leave cpu_rdata unchanged.
REQ-031 With no qualified ack and timeout counter = TIMEOUT: SHALL go to ERR.
REQ-032 If qualified ack and timeout occur in the same cycle, the ack SHALL win.
REQ-033 DONE: cpu_ack=1 for exactly one cycle, then go to IDLE.
REQ-034 ERR: cpu_err=1 for exactly one cycle, then go to IDLE.
REQ-035 ERR effects: on reads cpu_rdata=8'hFF; last_err_addr=latched addr; err_count increments, saturating at 255.
REQ-036 Latency: a zero-wait-state slot with dev_ack tied high SHALL give cpu_ack 2 cycles after cpu_cyc is first sampled.
REQ-037 Latency: a slot with ws_cfg=N SHALL give cpu_ack no earlier than N+2 cycles after cpu_cyc is first sampled.
REQ-038 If cpu_cyc is still high in IDLE after DONE or ERR, it SHALL start a new transaction (back-to-back supported).
REQ-039 dev_cyc and dev_we SHALL be 0 in IDLE, DONE and ERR.
REQ-040 dev_addr and dev_wdata SHALL remain stable for the whole ACCESS state.
REQ-041 Changes to ws_cfg or dev_en during ACCESS SHALL NOT affect the transaction in progress.
REQ-042 dev_ack from non-selected slots SHALL be ignored.

Reset
REQ-043 While rst_n=0 at a clock edge: state=IDLE; cpu_rdata, err_count, last_err_addr, the latches and both counters = 0; cpu_ack, cpu_err, dev_cyc and dev_we = 0.
REQ-044 A reset during ACCESS SHALL drop dev_cyc at that edge, with no ack or err issued.
REQ-045 The first transaction after reset SHALL start from IDLE.

Verification
REQ-046 Read with NDEV=4, addr=8'h45, dev_en=4'hF, ws_cfg[1]=0, dev_ack[1]=1, dev_rdata[1]=8'h5A -> dev_cyc=4'b0010, dev_addr=6'h05, cpu_ack at cycle 2, cpu_rdata=8'h5A.
REQ-047 Write to addr=8'hC3, data 8'h99, ws_cfg[3]=5, dev_ack[3] high -> dev_we[3] high for 6 cycles, cpu_ack at cycle 7, dev_wdata=8'h99, cpu_rdata unchanged.
REQ-048 Read to a disabled slot (dev_en=4'b1011, addr=8'h80) -> no dev_cyc, cpu_err at cycle 1, cpu_rdata=8'hFF, err_count=1, last_err_addr=8'h80.
REQ-049 Read to slot 0 with dev_ack[0] held low and TIMEOUT=31 -> dev_cyc[0] high for 32 cycles, then cpu_err, cpu_rdata=8'hFF; 300 such errors leave err_count=255.
REQ-050 Assert rst_n=0 in the 3rd ACCESS cycle of a 10-wait-state access -> dev_cyc=0, no cpu_ack or cpu_err; the next read completes normally.
REQ-051 Back-to-back: cpu_cyc held high across two reads to slots 0 and 2 -> two cpu_ack pulses separated by one IDLE cycle, each returning its own slot's data.

Source files
------------

// File: rtl/io_bus_fabric.sv
// CPU-to-device IO bus fabric: decodes the top address bits to a device slot,
// applies per-slot minimum wait states and an access timeout, and reports bus errors.
module io_bus_fabric #(
    parameter int NDEV    = 4,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 31
) (
    input  logic                             clk_i,
    input  logic                             rst_n,
    input  logic                             cpu_cyc,
    input  logic                             cpu_we,
    input  logic [ADDR_W-1:0]                cpu_addr,
    input  logic [7:0]                       cpu_wdata,
    output logic [7:0]                       cpu_rdata,
    output logic                             cpu_ack,
    output logic                             cpu_err,
    input  logic [NDEV-1:0]                  dev_en,
    input  logic [4*NDEV-1:0]                ws_cfg,
    output logic [NDEV-1:0]                  dev_cyc,
    output logic [NDEV-1:0]                  dev_we,
    output logic [ADDR_W-$clog2(NDEV)-1:0]   dev_addr,
    output logic [7:0]                       dev_wdata,
    input  logic [8*NDEV-1:0]                dev_rdata,
    input  logic [NDEV-1:0]                  dev_ack,
    output logic [7:0]                       err_count,
    output logic [ADDR_W-1:0]                last_err_addr
);
    localparam int SEL_W = $clog2(NDEV);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_t;

    state_t              r_state, w_next;
    logic [SEL_W-1:0]    r_sel;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [7:0]          r_wdata;
    logic [3:0]          r_wait;
    logic [TO_W-1:0]     r_tcnt;
    logic [7:0]          r_rdata;
    logic [7:0]          r_err_count;
    logic [ADDR_W-1:0]   r_last_err_addr;

    logic [SEL_W-1:0]    w_sel_in;
    logic                w_qack;
    logic                w_tout;
    logic                w_to_err;
    logic                w_err_we;
    logic [ADDR_W-1:0]   w_err_addr;

    assign w_sel_in = cpu_addr[ADDR_W-1 -: SEL_W];
    assign w_qack   = (r_wait == 4'd0) && dev_ack[r_sel];
    assign w_tout   = (r_tcnt == TO_W'(TIMEOUT));

    // An error raised straight from IDLE has not latched the request yet.
    assign w_to_err   = (w_next == S_ERR);
    assign w_err_we   = (r_state == S_IDLE) ? cpu_we   : r_we;
    assign w_err_addr = (r_state == S_IDLE) ? cpu_addr : r_addr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cpu_cyc) w_next = dev_en[w_sel_in] ? S_ACCESS : S_ERR;
            S_ACCESS: begin
                if (w_qack)      w_next = S_DONE;
                else if (w_tout) w_next = S_ERR;
            end
            S_DONE:   w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_sel           <= '0;
            r_addr          <= '0;
            r_we            <= 1'b0;
            r_wdata         <= '0;
            r_wait          <= '0;
            r_tcnt          <= '0;
            r_rdata         <= '0;
            r_err_count     <= '0;
            r_last_err_addr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && cpu_cyc) begin
                r_sel   <= w_sel_in;
                r_addr  <= cpu_addr;
                r_we    <= cpu_we;
                r_wdata <= cpu_wdata;
                r_wait  <= ws_cfg[4*w_sel_in +: 4];
                r_tcnt  <= '0;
            end
            if (r_state == S_ACCESS) begin
                if (r_wait != 4'd0) r_wait <= r_wait - 4'd1;
                r_tcnt <= r_tcnt + 1'b1;
                if (w_qack && !r_we) r_rdata <= dev_rdata[8*r_sel +: 8];
            end
            if (w_to_err) begin
                if (!w_err_we) r_rdata <= 8'hFF;
                r_last_err_addr <= w_err_addr;
                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    always_comb begin
        dev_cyc = '0;
        if (r_state == S_ACCESS) dev_cyc = NDEV'(1) << r_sel;
    end

    assign dev_we        = r_we ? dev_cyc : '0;
    assign dev_addr      = r_addr[ADDR_W-SEL_W-1:0];
    assign dev_wdata     = r_wdata;
    assign cpu_ack       = (r_state == S_DONE);
    assign cpu_err       = (r_state == S_ERR);
    assign cpu_rdata     = r_rdata;
    assign err_count     = r_err_count;
    assign last_err_addr = r_last_err_addr;
endmodule

// File: tb/tb_io_bus_fabric.sv
// Directed bench for io_bus_fabric with NDEV=4, ADDR_W=8, TIMEOUT=31.
module tb_io_bus_fabric;
    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        cpu_cyc, cpu_we;
    logic [7:0]  cpu_addr, cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack, cpu_err;
    logic [3:0]  dev_en;
    logic [15:0] ws_cfg;
    logic [3:0]  dev_cyc, dev_we;
    logic [5:0]  dev_addr;
    logic [7:0]  dev_wdata;
    logic [31:0] dev_rdata;
    logic [3:0]  dev_ack;
    logic [7:0]  err_count;
    logic [7:0]  last_err_addr;

    int vectors = 0;
    int miscompares = 0;

    io_bus_fabric #(.NDEV(4), .ADDR_W(8), .TIMEOUT(31)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .cpu_cyc(cpu_cyc), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .dev_en(dev_en), .ws_cfg(ws_cfg),
        .dev_cyc(dev_cyc), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_rdata(dev_rdata), .dev_ack(dev_ack), .err_count(err_count),
        .last_err_addr(last_err_addr)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Runs one CPU transaction; cycle numbers count edges after cpu_cyc is first sampled.
    task automatic run_txn(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                           output int done_cyc, output logic got_ack, output logic got_err,
                           output int ncyc, output int nwe, output logic [3:0] cyc_or,
                           output logic [5:0] addr_seen, output logic stable);
        logic first;
        done_cyc = -1; got_ack = 0; got_err = 0; ncyc = 0; nwe = 0;
        cyc_or = '0; addr_seen = '0; stable = 1; first = 1;
        cpu_cyc = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        for (int c = 1; c <= 100; c++) begin
            tick;
            if (dev_cyc != 0) begin
                ncyc++;
                cyc_or |= dev_cyc;
                if (first) addr_seen = dev_addr;
                else if (dev_addr !== addr_seen || dev_wdata !== wd) stable = 0;
                first = 0;
            end
            if (dev_we != 0) nwe++;
            if (cpu_ack || cpu_err) begin
                done_cyc = c; got_ack = cpu_ack; got_err = cpu_err;
                break;
            end
        end
        cpu_cyc = 0;
        tick;
    endtask

    int d, nc, nw;
    logic ga, ge, st;
    logic [3:0] co;
    logic [5:0] as;

    task automatic test_reset;
        rst_n = 0; cpu_cyc = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dev_en = 4'hF; ws_cfg = 0; dev_ack = 0;
        dev_rdata = {8'h33, 8'h22, 8'h5A, 8'h11};
        tick; tick;
        vectors++; if (cpu_ack !== 0 || cpu_err !== 0) begin miscompares++; $display("FAIL reset_ack_err: ack=%b err=%b want 0 0", cpu_ack, cpu_err); end
        vectors++; if (dev_cyc !== 0 || dev_we !== 0) begin miscompares++; $display("FAIL reset_dev: cyc=%b we=%b want 0", dev_cyc, dev_we); end
        vectors++; if (cpu_rdata !== 0) begin miscompares++; $display("FAIL reset_rdata: got %h want 00", cpu_rdata); end
        vectors++; if (err_count !== 0 || last_err_addr !== 0) begin miscompares++; $display("FAIL reset_err_regs: cnt=%h addr=%h want 0", err_count, last_err_addr); end
        vectors++; if (dev_addr !== 0 || dev_wdata !== 0) begin miscompares++; $display("FAIL reset_latches: addr=%h wdata=%h want 0", dev_addr, dev_wdata); end
        rst_n = 1;
        tick;
    endtask

    task automatic test_read_ws0;
        dev_en = 4'hF; ws_cfg = 0; dev_ack = 4'b0010;
        run_txn(0, 8'h45, 8'h00, d, ga, ge, nc, nw, co, as, st);
        vectors++; if (co !== 4'b0010) begin miscompares++; $display("FAIL rd0_dev_cyc: got %b want 0010", co); end
        vectors++; if (as !== 6'h05) begin miscompares++; $display("FAIL rd0_dev_addr: got %h want 05", as); end
        vectors++; if (d !== 2 || ga !== 1) begin miscompares++; $display("FAIL rd0_ack_cycle: cyc=%0d ack=%b want 2 1", d, ga); end
        vectors++; if (cpu_rdata !== 8'h5A) begin miscompares++; $display("FAIL rd0_rdata: got %h want 5a", cpu_rdata); end
        vectors++; if (nw !== 0) begin miscompares++; $display("FAIL rd0_no_we: got %0d want 0", nw); end
    endtask

    task automatic test_write_ws5;
        ws_cfg = 16'h5000; dev_ack = 4'b1000;
        run_txn(1, 8'hC3, 8'h99, d, ga, ge, nc, nw, co, as, st);
        vectors++; if (nw !== 6 || nc !== 6) begin miscompares++; $display("FAIL wr5_we_len: we=%0d cyc=%0d want 6 6", nw, nc); end
        vectors++; if (d !== 7 || ga !== 1) begin miscompares++; $display("FAIL wr5_ack_cycle: cyc=%0d ack=%b want 7 1", d, ga); end
        vectors++; if (dev_wdata !== 8'h99 || as !== 6'h03 || st !== 1) begin miscompares++; $display("FAIL wr5_data: wdata=%h addr=%h stable=%b want 99 03 1", dev_wdata, as, st); end
        vectors++; if (cpu_rdata !== 8'h5A) begin miscompares++; $display("FAIL wr5_rdata_kept: got %h want 5a", cpu_rdata); end
        vectors++; if (co !== 4'b1000) begin miscompares++; $display("FAIL wr5_dev_cyc: got %b want 1000", co); end
    endtask

    task automatic test_disabled;
        dev_en = 4'b1011; ws_cfg = 0; dev_ack = 4'hF;
        run_txn(0, 8'h80, 8'h00, d, ga, ge, nc, nw, co, as, st);
        vectors++; if (nc !== 0) begin miscompares++; $display("FAIL dis_no_cyc: got %0d want 0", nc); end
        vectors++; if (d !== 1 || ge !== 1 || ga !== 0) begin miscompares++; $display("FAIL dis_err_cycle: cyc=%0d err=%b ack=%b want 1 1 0", d, ge, ga); end
        vectors++; if (cpu_rdata !== 8'hFF) begin miscompares++; $display("FAIL dis_rdata: got %h want ff", cpu_rdata); end
        vectors++; if (err_count !== 8'd1 || last_err_addr !== 8'h80) begin miscompares++; $display("FAIL dis_err_regs: cnt=%0d addr=%h want 1 80", err_count, last_err_addr); end
        dev_en = 4'hF;
    endtask

    task automatic test_timeout;
        dev_ack = 4'b0010;
        run_txn(0, 8'h40, 8'h00, d, ga, ge, nc, nw, co, as, st);
        vectors++; if (cpu_rdata !== 8'h5A || ga !== 1) begin miscompares++; $display("FAIL to_pre_read: rdata=%h ack=%b want 5a 1", cpu_rdata, ga); end
        // Other slots acking must not complete a slot-0 access.
        dev_ack = 4'b1110;
        run_txn(0, 8'h00, 8'h00, d, ga, ge, nc, nw, co, as, st);
        vectors++; if (nc !== 32 || co !== 4'b0001) begin miscompares++; $display("FAIL to_cyc_len: got %0d %b want 32 0001", nc, co); end
        vectors++; if (d !== 33 || ge !== 1 || ga !== 0) begin miscompares++; $display("FAIL to_err_cycle: cyc=%0d err=%b ack=%b want 33 1 0", d, ge, ga); end
        vectors++; if (cpu_rdata !== 8'hFF) begin miscompares++; $display("FAIL to_rdata: got %h want ff", cpu_rdata); end
        vectors++; if (err_count !== 8'd2 || last_err_addr !== 8'h00) begin miscompares++; $display("FAIL to_err_regs: cnt=%0d addr=%h want 2 00", err_count, last_err_addr); end
        for (int i = 0; i < 299; i++) run_txn(0, 8'h00, 8'h00, d, ga, ge, nc, nw, co, as, st);
        vectors++; if (err_count !== 8'd255 || ge !== 1) begin miscompares++; $display("FAIL to_saturate: cnt=%0d err=%b want 255 1", err_count, ge); end
    endtask

    task automatic test_cfg_change;
        int c;
        dev_en = 4'hF; ws_cfg = 16'h0030; dev_ack = 4'b0010;
        cpu_cyc = 1; cpu_we = 0; cpu_addr = 8'h41; cpu_wdata = 0;
        tick;
        ws_cfg = 0; dev_en = 0;
        c = 1;
        while (!cpu_ack && !cpu_err && c < 60) begin tick; c++; end
        cpu_cyc = 0;
        vectors++; if (c !== 5 || cpu_ack !== 1) begin miscompares++; $display("FAIL cfg_hold: cyc=%0d ack=%b want 5 1", c, cpu_ack); end
        tick;
        dev_en = 4'hF;
    endtask

    task automatic test_back_to_back;
        dev_ack = 4'hF; ws_cfg = 0;
        cpu_cyc = 1; cpu_we = 0; cpu_addr = 8'h00;
        tick; tick;
        vectors++; if (cpu_ack !== 1 || cpu_rdata !== 8'h11) begin miscompares++; $display("FAIL b2b_first: ack=%b rdata=%h want 1 11", cpu_ack, cpu_rdata); end
        cpu_addr = 8'h80;
        tick;
        vectors++; if (cpu_ack !== 0 || dev_cyc !== 0) begin miscompares++; $display("FAIL b2b_gap: ack=%b cyc=%b want 0 0", cpu_ack, dev_cyc); end
        tick;
        vectors++; if (dev_cyc !== 4'b0100) begin miscompares++; $display("FAIL b2b_second_cyc: got %b want 0100", dev_cyc); end
        tick;
        vectors++; if (cpu_ack !== 1 || cpu_rdata !== 8'h22) begin miscompares++; $display("FAIL b2b_second: ack=%b rdata=%h want 1 22", cpu_ack, cpu_rdata); end
        cpu_cyc = 0;
        tick;
    endtask

    task automatic test_reset_mid_access;
        logic seen;
        ws_cfg = 16'h0A00; dev_ack = 4'b0100;
        cpu_cyc = 1; cpu_we = 0; cpu_addr = 8'h80;
        tick; tick; tick;
        vectors++; if (dev_cyc !== 4'b0100) begin miscompares++; $display("FAIL rst_pre_cyc: got %b want 0100", dev_cyc); end
        rst_n = 0;
        tick;
        vectors++; if (dev_cyc !== 0 || cpu_ack !== 0 || cpu_err !== 0) begin miscompares++; $display("FAIL rst_drop: cyc=%b ack=%b err=%b want 0 0 0", dev_cyc, cpu_ack, cpu_err); end
        vectors++; if (err_count !== 0) begin miscompares++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
        rst_n = 1; cpu_cyc = 0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin tick; if (cpu_ack || cpu_err) seen = 1; end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rst_no_completion: got %b want 0", seen); end
        run_txn(0, 8'h80, 8'h00, d, ga, ge, nc, nw, co, as, st);
        vectors++; if (d !== 12 || ga !== 1 || cpu_rdata !== 8'h22) begin miscompares++; $display("FAIL rst_next_read: cyc=%0d ack=%b rdata=%h want 12 1 22", d, ga, cpu_rdata); end
    endtask

    initial begin
        test_reset;
        test_read_ws0;
        test_write_ws5;
        test_disabled;
        test_timeout;
        test_cfg_change;
        test_back_to_back;
        test_reset_mid_access;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
